// File: rtl/sna_pkg.sv
// sna_pkg: shared constants, FSM state type and index-width helper for serial_nibble_adder.
`default_nettype none

package sna_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Nibble index width; at least one bit so a single-nibble adder still has a counter.
  function automatic int nib_idx_w(input int width);
    int n;
    int w;
    n = width / NIB_W;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_add4.sv
// nibble_add4: combinational 4-bit ripple-carry slice built from full-adder equations.
`default_nettype none

module nibble_add4
  import sna_pkg::*;
(
  input  logic [NIB_W-1:0] a4,
  input  logic [NIB_W-1:0] b4,
  input  logic             ci,
  output logic [NIB_W-1:0] s4,
  output logic             co
);

  logic [NIB_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < NIB_W; i++) begin : g_bit
    assign s4[i]   = a4[i] ^ b4[i] ^ c[i];
    assign c[i+1]  = (a4[i] & b4[i]) | (c[i] & (a4[i] ^ b4[i]));
  end

  assign co = c[NIB_W];

endmodule

`default_nettype wire

// File: rtl/serial_nibble_adder.sv
// serial_nibble_adder: WIDTH-bit adder computed one nibble per clock through a single slice.
// Optional signed-overflow output enabled by defining SNA_OVERFLOW_EN.
`default_nettype none

module serial_nibble_adder
  import sna_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SNA_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int                N        = WIDTH / NIB_W;
  localparam int                IDX_W    = nib_idx_w(WIDTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cout_q, cout_d;
`ifdef SNA_OVERFLOW_EN
  logic               ovf_q, ovf_d;
`endif

  logic [NIB_W-1:0]   a_nib, b_nib, s_nib;
  logic               co_nib;

  assign a_nib = a_q[idx_q*NIB_W +: NIB_W];
  assign b_nib = b_q[idx_q*NIB_W +: NIB_W];

  nibble_add4 u_slice (
    .a4 (a_nib),
    .b4 (b_nib),
    .ci (carry_q),
    .s4 (s_nib),
    .co (co_nib)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
`ifdef SNA_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef SNA_OVERFLOW_EN
          ovf_d   = 1'b0;
`endif
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*NIB_W +: NIB_W] = s_nib;
        carry_d = co_nib;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          done_d  = 1'b1;
          cout_d  = co_nib;
`ifdef SNA_OVERFLOW_EN
          // Carry into the MSB is recovered from the MSB sum bit of the last slice.
          ovf_d   = co_nib ^ (a_nib[NIB_W-1] ^ b_nib[NIB_W-1] ^ s_nib[NIB_W-1]);
`endif
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SNA_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
`ifdef SNA_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SNA_OVERFLOW_EN
  assign ovf  = ovf_q;
`endif

endmodule

`default_nettype wire
